// File: rtl/spi_pkg.sv
// Shared encodings for the multi-slave SPI master: FSM states and {cpol,cpha} mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider: free-runs while enabled and pulses tick on the last count.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Held at zero while disabled so every phase starts with a full half-period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (!en || tick)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: N chip selects, runtime CPOL/CPHA, one full-duplex word per start.
// Optional SPI_LSB_FIRST_EN adds a lsb_first input that reverses the shift order.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int CLK_DIV    = 2,
  localparam int SS_W      = $clog2(NUM_SLAVES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SS_W-1:0]       SLAVE_SELECT,
  input  logic                  cpol,
  input  logic                  cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  lsb_first,
`endif
  input  logic [DATA_W-1:0]     tx_data,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NUM_SLAVES-1:0] CS_n
);

  localparam int ECW = $clog2(2 * DATA_W);
  localparam int IW  = ECW - 1;
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_W - 1);
  localparam logic [IW-1:0]  MSB_IDX   = IW'(DATA_W - 1);
  localparam logic [SS_W:0]  NS        = (SS_W + 1)'(NUM_SLAVES);

  spi_state_e        state;
  logic              cpol_l, cpha_l, lsb_l;
  logic [DATA_W-1:0] tx_l, rx_sh;
  logic [ECW-1:0]    edge_cnt;
  logic              tick;
  logic              lsb_in;
  logic [IW-1:0]     bit_i;
  logic              leading;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Each data bit spans one leading + one trailing SCK edge.
  assign bit_i   = edge_cnt[ECW-1:1];
  assign leading = ~edge_cnt[0];

  function automatic logic [IW-1:0] bit_pos(input logic [IW-1:0] i, input logic lsb);
    return lsb ? i : (MSB_IDX - i);
  endfunction

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (state != IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      CS_n     <= '1;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
      tx_l     <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          SCK  <= cpol_l;
          CS_n <= '1;
          if (start && ({1'b0, SLAVE_SELECT} < NS)) begin
            state              <= SETUP;
            busy               <= 1'b1;
            cpol_l             <= cpol;
            cpha_l             <= cpha;
            lsb_l              <= lsb_in;
            tx_l               <= tx_data;
            rx_sh              <= '0;
            edge_cnt           <= '0;
            // SCK settles to the new idle level as CS asserts, before any data edge.
            SCK                <= cpol;
            MOSI               <= tx_data[bit_pos('0, lsb_in)];
            CS_n[SLAVE_SELECT] <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) state <= TRANSFER;
        end
        TRANSFER: begin
          if (tick) begin
            SCK      <= ~SCK;
            edge_cnt <= edge_cnt + 1'b1;
            if (leading ^ cpha_l)
              rx_sh[bit_pos(bit_i, lsb_l)] <= MISO;
            else if (cpha_l)
              MOSI <= tx_l[bit_pos(bit_i, lsb_l)];
            else if (edge_cnt != LAST_EDGE)
              MOSI <= tx_l[bit_pos(bit_i + 1'b1, lsb_l)];
            if (edge_cnt == LAST_EDGE) state <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            CS_n    <= '1;
            rx_data <= rx_sh;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a behavioural SPI slave; honours SPI_LSB_FIRST_EN.
module tb_spi_master_multi;
  import spi_pkg::*;

  // Five slaves so an in-width but out-of-range SLAVE_SELECT (5..7) exists.
  localparam int DW = 8;
  localparam int NS = 5;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    SLAVE_SELECT = '0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
`ifdef SPI_LSB_FIRST_EN
  logic          lsb_first = 1'b0;
`endif
  logic [DW-1:0] tx_data = '0;
  logic          MISO = 1'b0;
  wire  [DW-1:0] rx_data;
  wire           busy, done, SCK, MOSI;
  wire  [NS-1:0] CS_n;

  int passed = 0;
  int total  = 0;

  spi_master_multi #(.DATA_W(DW), .NUM_SLAVES(NS), .CLK_DIV(CD)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .SLAVE_SELECT (SLAVE_SELECT),
    .cpol         (cpol),
    .cpha         (cpha),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first    (lsb_first),
`endif
    .tx_data      (tx_data),
    .rx_data      (rx_data),
    .busy         (busy),
    .done         (done),
    .SCK          (SCK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .CS_n         (CS_n)
  );

  always #5 clk = ~clk;

  // Behavioural slave, polled on the falling clk edge so it never races the master's edges.
  logic          m_cpha = 1'b0, m_lsb = 1'b0, s_act = 1'b0, s_prev = 1'b0;
  logic [DW-1:0] s_tx = '0, s_rx = '0;
  logic [NS-1:0] s_seen = '0;
  int            s_edges = 0;

  function automatic int spos(input int i, input logic lsb);
    return lsb ? i : (DW - 1 - i);
  endfunction

  always @(negedge clk) begin
    if (CS_n === '1) begin
      s_act = 1'b0;
    end else if (!s_act) begin
      s_act   = 1'b1;
      s_edges = 0;
      s_prev  = SCK;
      s_rx    = '0;
      s_seen  = s_seen | ~CS_n;
      if (!m_cpha) MISO = s_tx[spos(0, m_lsb)];
    end else begin
      s_seen = s_seen | ~CS_n;
      if (SCK !== s_prev) begin
        int bi;
        logic lead;
        s_prev  = SCK;
        s_edges = s_edges + 1;
        bi      = (s_edges - 1) / 2;
        lead    = (s_edges % 2) == 1;
        if (lead != m_cpha)  s_rx[spos(bi, m_lsb)] = MOSI;
        else if (m_cpha)     MISO = s_tx[spos(bi, m_lsb)];
        else if (bi < DW-1)  MISO = s_tx[spos(bi + 1, m_lsb)];
      end
    end
  end

  // Cycle 1 is the cycle right after the edge that samples start.
  task automatic run_xfer(input logic [2:0] sel, input logic [1:0] mode, input logic lsb,
                          input logic [DW-1:0] tx, input logic [DW-1:0] stx, input int inj,
                          output int dcyc, output int bcyc, output int ndone,
                          output logic sck1, output logic mosi1, output logic sck_end);
    m_cpha = mode[0];
    m_lsb  = lsb;
    s_tx   = stx;
    s_seen = '0;
    @(negedge clk);
    SLAVE_SELECT = sel;
    cpol         = mode[1];
    cpha         = mode[0];
    tx_data      = tx;
`ifdef SPI_LSB_FIRST_EN
    lsb_first    = lsb;
`endif
    start        = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    dcyc    = 0;
    bcyc    = 0;
    ndone   = 0;
    sck1    = SCK;
    mosi1   = MOSI;
    sck_end = 1'bx;
    for (int c = 1; c <= 100; c++) begin
      if (busy) bcyc++;
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = c;
      end
      if (dcyc != 0 && c == dcyc + 3) begin
        sck_end = SCK;
        break;
      end
      if (c == inj) begin
        start        = 1'b1;
        SLAVE_SELECT = 3'd0;
        tx_data      = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++; if (CS_n !== 5'h1F) $display("FAIL reset_cs_n got=%h exp=1f", CS_n); else passed++;
    total++; if (SCK !== 1'b0) $display("FAIL reset_sck got=%b exp=0", SCK); else passed++;
    total++; if (MOSI !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", MOSI); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL reset_rx got=%h exp=00", rx_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mode0();
    int dc, bc, nd;
    logic s1, m1, se;
    run_xfer(3'd2, SPI_MODE0, 1'b0, 8'hA5, 8'h3C, 0, dc, bc, nd, s1, m1, se);
    total++; if (rx_data !== 8'h3C) $display("FAIL m0_rx got=%h exp=3c", rx_data); else passed++;
    total++; if (s_rx !== 8'hA5) $display("FAIL m0_slave_rx got=%h exp=a5", s_rx); else passed++;
    total++; if (s_seen !== 5'b00100) $display("FAIL m0_cs_seen got=%b exp=00100", s_seen); else passed++;
    total++; if (dc != 37) $display("FAIL m0_done_cycle got=%0d exp=37", dc); else passed++;
    total++; if (bc != 36) $display("FAIL m0_busy_cycles got=%0d exp=36", bc); else passed++;
    total++; if (nd != 1) $display("FAIL m0_done_count got=%0d exp=1", nd); else passed++;
    total++; if (s_edges != 16) $display("FAIL m0_sck_edges got=%0d exp=16", s_edges); else passed++;
    total++; if (m1 !== 1'b1) $display("FAIL m0_first_mosi got=%b exp=1", m1); else passed++;
  endtask

  task automatic test_modes();
    logic [1:0] modes [3];
    modes = '{SPI_MODE1, SPI_MODE2, SPI_MODE3};
    for (int i = 0; i < 3; i++) begin
      int dc, bc, nd;
      logic s1, m1, se;
      logic [1:0] md;
      md = modes[i];
      run_xfer(3'd1, md, 1'b0, 8'h81, 8'h7E, 0, dc, bc, nd, s1, m1, se);
      total++; if (rx_data !== 8'h7E) $display("FAIL mode%0d_rx got=%h exp=7e", i+1, rx_data); else passed++;
      total++; if (s_rx !== 8'h81) $display("FAIL mode%0d_slave_rx got=%h exp=81", i+1, s_rx); else passed++;
      total++; if (s1 !== md[1]) $display("FAIL mode%0d_sck_before got=%b exp=%b", i+1, s1, md[1]); else passed++;
      total++; if (se !== md[1]) $display("FAIL mode%0d_sck_after got=%b exp=%b", i+1, se, md[1]); else passed++;
    end
  endtask

  task automatic test_ignore_busy();
    int dc, bc, nd;
    logic s1, m1, se;
    run_xfer(3'd1, SPI_MODE0, 1'b0, 8'h5A, 8'hC3, 10, dc, bc, nd, s1, m1, se);
    total++; if (s_seen !== 5'b00010) $display("FAIL ign_cs_seen got=%b exp=00010", s_seen); else passed++;
    total++; if (nd != 1) $display("FAIL ign_done_count got=%0d exp=1", nd); else passed++;
    total++; if (rx_data !== 8'hC3) $display("FAIL ign_rx got=%h exp=c3", rx_data); else passed++;
    total++; if (dc != 37) $display("FAIL ign_done_cycle got=%0d exp=37", dc); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ign_not_queued got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [2:0] sels [2];
    sels = '{3'd5, 3'd7};
    for (int i = 0; i < 2; i++) begin
      logic sb, sc, sd;
      sb = 1'b0; sc = 1'b0; sd = 1'b0;
      @(negedge clk);
      SLAVE_SELECT = sels[i];
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (busy !== 1'b0) sb = 1'b1;
        if (CS_n !== 5'h1F) sc = 1'b1;
        if (done !== 1'b0) sd = 1'b1;
        @(negedge clk);
      end
      total++; if (sb) $display("FAIL oor%0d_busy got=1 exp=0", sels[i]); else passed++;
      total++; if (sc) $display("FAIL oor%0d_cs got=active exp=1f", sels[i]); else passed++;
      total++; if (sd) $display("FAIL oor%0d_done got=1 exp=0", sels[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic found, sd;
    int dc, bc, nd;
    logic s1, m1, se;
    m_cpha = 1'b0; m_lsb = 1'b0; s_tx = 8'hFF; s_seen = '0;
    @(negedge clk);
    SLAVE_SELECT = 3'd3; cpol = 1'b0; cpha = 1'b0; tx_data = 8'hF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (s_act && s_edges == 7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!found) $display("FAIL rst_mid_reach_edge7 got=timeout exp=edge7"); else passed++;
    reset = 1'b0;
    #1;
    total++; if (CS_n !== 5'h1F) $display("FAIL rst_mid_cs got=%h exp=1f", CS_n); else passed++;
    total++; if (SCK !== 1'b0) $display("FAIL rst_mid_sck got=%b exp=0", SCK); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL rst_mid_rx got=%h exp=00", rx_data); else passed++;
    @(negedge clk);
    reset = 1'b1;
    sd = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) sd = 1'b1;
      @(negedge clk);
    end
    total++; if (sd) $display("FAIL rst_mid_no_done got=1 exp=0"); else passed++;
    run_xfer(3'd3, SPI_MODE0, 1'b0, 8'h3C, 8'hA5, 0, dc, bc, nd, s1, m1, se);
    total++; if (rx_data !== 8'hA5) $display("FAIL rst_after_rx got=%h exp=a5", rx_data); else passed++;
    total++; if (s_rx !== 8'h3C) $display("FAIL rst_after_slave_rx got=%h exp=3c", s_rx); else passed++;
    total++; if (dc != 37) $display("FAIL rst_after_done_cycle got=%0d exp=37", dc); else passed++;
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first();
    int dc, bc, nd;
    logic s1, m1, se;
    run_xfer(3'd4, SPI_MODE0, 1'b1, 8'h01, 8'h80, 0, dc, bc, nd, s1, m1, se);
    total++; if (m1 !== 1'b1) $display("FAIL lsb_first_mosi got=%b exp=1", m1); else passed++;
    total++; if (rx_data !== 8'h80) $display("FAIL lsb_rx got=%h exp=80", rx_data); else passed++;
    total++; if (s_rx !== 8'h01) $display("FAIL lsb_slave_rx got=%h exp=01", s_rx); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_ignore_busy();
    test_out_of_range();
    test_reset_mid();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
